slave_rd_resp: RTL and testbench
================================

Name: slave_rd_resp

Overview:
- Pipelined register-slave read-response block with a valid/ready handshake.
- Captures one selected word from a flat vector of register words on each accepted read request, and flags select errors.
- Queues responses in a small FIFO so the bus-side consumer may stall without losing reads.
- Sits between the register-file decode (one-hot word select) and the slave response channel.

Parameters:
- W_WIDTH, 32, bits per register word.
- W_CNT, 5, number of words; also the width of the one-hot select.
- RSP_DEPTH, 2, response FIFO entries; legal values are 1 to 16.

Ports:
- clk  input  1  clock, all state rising-edge.
- rst  input  1  asynchronous active-high reset.
- rd_req  input  1  read request, qualified by rd_req_rdy.
- rd_req_rdy  output  1  block can accept a request this cycle.
- rd_words  input  W_CNT  one-hot word select, sampled with rd_req.
- all_words  input  W_WIDTH*W_CNT  word k occupies bits [k*W_WIDTH +: W_WIDTH].
- rd_vld  output  1  response valid.
- rd_rdy  input  1  consumer accepts the response.
- rd_data  output  W_WIDTH  response data.
- rd_err  output  1  response select error.
- rsp_cnt  output  $clog2(RSP_DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (async assert on rst=1, sync deassert from the consumer's view):
  - rd_vld=0, rd_data=0, rd_err=0, rsp_cnt=0, rd_req_rdy=1 once the FIFO is empty.
  - Read/write pointers cleared; all in-flight responses discarded, no partial response emitted.
- Accept: push occurs on the rising edge where rd_req && rd_req_rdy.
  - rd_req_rdy = (rsp_cnt != RSP_DEPTH).
  - Full-case rule is conservative: no pass-through when full, even if a pop happens in the same cycle.
- Selection (combinational at accept, result stored in the FIFO entry):
  - popcount(rd_words)==1: data = selected word, err = 0.
  - popcount(rd_words)==0: data = 0, err = 1.
  - popcount(rd_words)>1: see Optional Feature; err = 1 in all cases.
- all_words is sampled only at accept; later changes do not affect queued entries.
- Latency: an accept at edge N into an empty FIFO gives rd_vld=1 after edge N (one cycle). No combinational path from rd_req to rd_vld.
- Output: rd_vld = (rsp_cnt != 0).
  - rd_data and rd_err show the head entry when rd_vld=1, and are forced to 0 when rd_vld=0.
- Pop on the edge where rd_vld && rd_rdy. rd_data and rd_err must stay stable while rd_vld && !rd_rdy.
- Simultaneous push and pop with 0 < rsp_cnt < RSP_DEPTH: occupancy unchanged, both pointers advance.
- Simultaneous push and pop at rsp_cnt==0: impossible, since rd_vld=0.
- Pointers run from 0 to RSP_DEPTH-1 and wrap explicitly to 0; RSP_DEPTH need not be a power of two.
- rsp_cnt updates on every edge: +1 push only, -1 pop only, otherwise unchanged.
- Ignored inputs:
  - rd_req while rd_req_rdy=0 is dropped; the requester must hold it.
  - rd_rdy while rd_vld=0 has no effect.
- Response order equals request order.

Optional Feature:
- Macro SLAVE_RD_MULTI_OR_EN.
- Defined: a multi-hot select returns the bitwise OR of all selected words, with err=1.
- Undefined: a multi-hot select returns data=0, with err=1.
- Zero-hot and one-hot behaviour are identical in both builds.

Test Plan:
- Reset then single read: W_CNT=5, words k = 32'h1000_000k, rd_req with rd_words=5'b00100, rd_rdy=1 → one cycle later rd_vld=1, rd_data=32'h1000_0002, rd_err=0; next cycle rd_vld=0, rd_data=0.
- Back-pressure fill: rd_rdy=0, RSP_DEPTH=2, three consecutive requests for words 0, 1, 3 → first two accepted, rsp_cnt=2, rd_req_rdy=0, third held. After rd_rdy=1 the responses appear in order 1000_0000, 1000_0001, then 1000_0003.
- Data stability: change all_words while an entry is queued and stalled → rd_data keeps the sampled value until popped.
- Select errors, rd_words=5'b00000 → rd_data=0, rd_err=1.
- Select errors, rd_words=5'b00011 → rd_err=1; rd_data=0 without the macro, 32'h1000_0001 with SLAVE_RD_MULTI_OR_EN.
- Streaming: rd_req and rd_rdy held at 1 for 10 cycles cycling through words 0-4 → one response per cycle, rsp_cnt stays 1, pointers wrap correctly.
- Reset mid-operation: assert rst asynchronously with rsp_cnt=2 → rd_vld=0, rsp_cnt=0 immediately. After release, a new request returns fresh data with no stale entries.

Source files
------------

// File: rtl/slave_rd_resp.sv
// Register-slave read-response block: one-hot word capture into a small response FIFO.
// Optional macro SLAVE_RD_MULTI_OR_EN: multi-hot selects return the OR of the selected words.
module slave_rd_resp #(
  parameter int W_WIDTH   = 32,
  parameter int W_CNT     = 5,
  parameter int RSP_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rd_req,
  output logic                           rd_req_rdy,
  input  logic [W_CNT-1:0]               rd_words,
  input  logic [W_WIDTH*W_CNT-1:0]       all_words,
  output logic                           rd_vld,
  input  logic                           rd_rdy,
  output logic [W_WIDTH-1:0]             rd_data,
  output logic                           rd_err,
  output logic [$clog2(RSP_DEPTH+1)-1:0] rsp_cnt
);
  // Handshakes: a request transfers on a rising edge with rd_req && rd_req_rdy;
  // a response transfers on a rising edge with rd_vld && rd_rdy. The offering
  // side holds its payload stable until the transfer happens.

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [W_WIDTH:0]   mem_q [RSP_DEPTH];
  logic [W_WIDTH:0]   head;
  logic [W_WIDTH-1:0] sel_or;
  logic [W_WIDTH-1:0] new_data;
  logic               new_err;
  logic               one_hot;
  logic               push, pop;

  // Explicit wrap so RSP_DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    sel_or  = '0;
    one_hot = (rd_words != '0) && ((rd_words & (rd_words - W_CNT'(1))) == '0);
    for (int k = 0; k < W_CNT; k++) begin
      if (rd_words[k]) sel_or = sel_or | all_words[k*W_WIDTH +: W_WIDTH];
    end
    new_err = !one_hot;
`ifdef SLAVE_RD_MULTI_OR_EN
    new_data = sel_or;
`else
    new_data = one_hot ? sel_or : '0;
`endif
  end

  // A full FIFO refuses requests even when a pop lands on the same edge.
  assign rd_req_rdy = (cnt_q != CW'(RSP_DEPTH));
  assign rd_vld     = (cnt_q != '0);
  assign push       = rd_req && rd_req_rdy;
  assign pop        = rd_vld && rd_rdy;

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted as valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {new_err, new_data};
  end

  assign head    = mem_q[rd_ptr_q];
  assign rd_data = rd_vld ? head[W_WIDTH-1:0] : '0;
  assign rd_err  = rd_vld ? head[W_WIDTH] : 1'b0;
  assign rsp_cnt = cnt_q;

endmodule

// File: tb/tb_slave_rd_resp.sv
// Bench for slave_rd_resp: directed scenarios plus random traffic against a queue model.
module tb_slave_rd_resp;
  localparam int W  = 32;
  localparam int N  = 5;
  localparam int D  = 2;
  localparam int CW = $clog2(D + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           rd_req;
  logic           rd_req_rdy;
  logic [N-1:0]   rd_words;
  logic [W*N-1:0] all_words;
  logic           rd_vld;
  logic           rd_rdy;
  logic [W-1:0]   rd_data;
  logic           rd_err;
  logic [CW-1:0]  rsp_cnt;

  int vectors     = 0;
  int miscompares = 0;
  logic [W:0] exp_q[$];  // {err, data} in request order

  slave_rd_resp #(.W_WIDTH(W), .W_CNT(N), .RSP_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_req_rdy(rd_req_rdy),
    .rd_words(rd_words), .all_words(all_words), .rd_vld(rd_vld),
    .rd_rdy(rd_rdy), .rd_data(rd_data), .rd_err(rd_err), .rsp_cnt(rsp_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] ref_rsp(input logic [N-1:0] sel, input logic [W*N-1:0] words);
    logic [W-1:0] acc = '0;
    int hits = $countones(sel);
    for (int k = 0; k < N; k++) if (sel[k]) acc = acc | words[k*W +: W];
    if (hits == 1) return {1'b0, acc};
    if (hits == 0) return {1'b1, {W{1'b0}}};
`ifdef SLAVE_RD_MULTI_OR_EN
    return {1'b1, acc};
`else
    return {1'b1, {W{1'b0}}};
`endif
  endfunction

  function automatic logic [W*N-1:0] base_words();
    logic [W*N-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = 32'h1000_0000 + k;
    return v;
  endfunction

  // One clock: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic step(output bit acc);
    logic [W:0] head, entry;
    bit push, pop;
    @(negedge clk);
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk("rd_vld",     W'(rd_vld),     W'(exp_q.size() != 0));
    chk("rd_req_rdy", W'(rd_req_rdy), W'(exp_q.size() < D));
    chk("rsp_cnt",    W'(rsp_cnt),    W'(exp_q.size()));
    chk("rd_data",    rd_data,        head[W-1:0]);
    chk("rd_err",     W'(rd_err),     W'(head[W]));
    push  = rd_req && (exp_q.size() < D);
    pop   = (exp_q.size() != 0) && rd_rdy;
    entry = ref_rsp(rd_words, all_words);
    @(posedge clk);
    if (pop)  void'(exp_q.pop_front());
    if (push) exp_q.push_back(entry);
    acc = push;
    #1;
  endtask

  task automatic req_wait();
    bit acc = 0;
    for (int i = 0; i < 20 && !acc; i++) step(acc);
    chk("req_accept_timeout", W'(acc), W'(1));
    rd_req = 1'b0;
  endtask

  task automatic req(input logic [N-1:0] sel);
    rd_req   = 1'b1;
    rd_words = sel;
    req_wait();
  endtask

  task automatic drain();
    bit acc;
    rd_rdy = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(acc);
    chk("drain_timeout", W'(exp_q.size()), W'(0));
  endtask

  initial begin
    bit acc;
    rst = 1'b1; rd_req = 1'b0; rd_rdy = 1'b0; rd_words = '0;
    all_words = base_words();
    #12;
    chk("rst_vld",  W'(rd_vld),     W'(0));
    chk("rst_cnt",  W'(rsp_cnt),    W'(0));
    chk("rst_rdy",  W'(rd_req_rdy), W'(1));
    chk("rst_data", rd_data,        W'(0));
    @(posedge clk); #1 rst = 1'b0;

    // Single read with one-cycle latency.
    rd_rdy = 1'b1;
    req(5'b00100);
    chk("single_vld",  W'(rd_vld), W'(1));
    chk("single_data", rd_data,    32'h1000_0002);
    chk("single_err",  W'(rd_err), W'(0));
    step(acc);
    chk("single_gone", W'(rd_vld), W'(0));

    // Back-pressure fill: third request held while full.
    rd_rdy = 1'b0;
    req(5'b00001);
    req(5'b00010);
    rd_req = 1'b1; rd_words = 5'b01000;
    step(acc); step(acc);
    chk("full_cnt", W'(rsp_cnt),    W'(2));
    chk("full_rdy", W'(rd_req_rdy), W'(0));
    // Stalled head keeps its sampled value when the source word changes.
    all_words[0 +: W] = 32'hDEAD_BEEF;
    step(acc);
    chk("stable_data", rd_data, 32'h1000_0000);
    rd_rdy = 1'b1;
    req_wait();
    drain();
    all_words = base_words();

    // Select errors.
    req(5'b00000);
    chk("zero_data", rd_data,    W'(0));
    chk("zero_err",  W'(rd_err), W'(1));
    step(acc);
    req(5'b00011);
    chk("multi_err", W'(rd_err), W'(1));
`ifdef SLAVE_RD_MULTI_OR_EN
    chk("multi_data", rd_data, 32'h1000_0001);
`else
    chk("multi_data", rd_data, 32'h0000_0000);
`endif
    drain();

    // Streaming through all words; pointers wrap repeatedly.
    rd_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rd_words = N'(1) << (i % N);
      step(acc);
      if (i > 0) chk("stream_cnt", W'(rsp_cnt), W'(1));
    end
    rd_req = 1'b0;
    drain();

    // Asynchronous reset with two entries queued.
    rd_rdy = 1'b0;
    req(5'b00001);
    req(5'b00010);
    #3 rst = 1'b1;
    #1;
    chk("midrst_vld", W'(rd_vld),  W'(0));
    chk("midrst_cnt", W'(rsp_cnt), W'(0));
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    rd_rdy = 1'b1;
    req(5'b10000);
    chk("post_rst_data", rd_data, 32'h1000_0004);
    drain();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rd_req = 1'($urandom_range(0, 1));
      rd_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) rd_words = N'($urandom);
      else rd_words = N'(1) << $urandom_range(0, N - 1);
      if ($urandom_range(0, 7) == 0) all_words[$urandom_range(0, N - 1)*W +: W] = $urandom;
      step(acc);
    end
    rd_req = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
